scr1_dmi_chain_core: RTL and testbench

SysCLK-domain responder for the JTAG DMI scan chains. It consumes the single-cycle capture/shift/update/TDI strobes that the TAP clock-domain synchronizer delivers, and holds the DTMCS and DMI-access shift registers. It drives the serial TDO bit back toward the TAP. It converts completed DMI-access updates into read/write requests to the Debug Module and returns the DM response on the next capture.

---
 rtl/scr1_dmi_chain_core.sv | 147 ++++++++++++++
 tb/tb_scr1_dmi_chain_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmi_chain_core.sv
// ============================================================================
// scr1_dmi_chain_core : SysCLK-side DTMCS/DMI scan-chain responder and DM requester
// Revision 1.0
// ============================================================================
`default_nettype none

module scr1_dmi_chain_core #(
    parameter int ABITS       = 7,
    parameter int DBITS       = 32,
    parameter int CH_ID_W     = 2,
    parameter int CH_ID_DTMCS = 0,
    parameter int CH_ID_DMI   = 1
) (
    input  logic               clk,
    input  logic               trst_n,
    input  logic               dmi_ch_sel_core,
    input  logic [CH_ID_W-1:0] dmi_ch_id_core,
    input  logic               dmi_ch_capture_core,
    input  logic               dmi_ch_shift_core,
    input  logic               dmi_ch_update_core,
    input  logic               dmi_ch_tdi_core,
    output logic               dmi_ch_tdo_core,
    output logic               dmi_req,
    input  logic               dmi_req_ack,
    output logic               dmi_req_wr,
    output logic [ABITS-1:0]   dmi_req_addr,
    output logic [DBITS-1:0]   dmi_req_wdata,
    input  logic               dmi_resp_valid,
    input  logic               dmi_resp_err,
    input  logic [DBITS-1:0]   dmi_resp_rdata
);

    localparam int SR_W = ABITS + DBITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [1:0]        sticky_q, sticky_d;
    logic [ABITS-1:0]  addr_q, addr_d;
    logic [DBITS-1:0]  wdata_q, wdata_d;
    logic [DBITS-1:0]  rdata_q, rdata_d;
    logic              wr_q, wr_d;

    logic        ch_dtmcs;
    logic        ch_dmi;
    logic [31:0] dtmcs_cap;
    logic [1:0]  upd_op;

    assign ch_dtmcs  = dmi_ch_sel_core && (dmi_ch_id_core == CH_ID_W'(CH_ID_DTMCS));
    assign ch_dmi    = dmi_ch_sel_core && (dmi_ch_id_core == CH_ID_W'(CH_ID_DMI));
    assign dtmcs_cap = {17'd0, 3'd1, sticky_q, 6'(ABITS), 4'd1};
    assign upd_op    = sr_q[1:0];

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        sticky_d = sticky_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;

        case (state_q)
            ST_REQ: begin
                if (dmi_req_ack) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (dmi_resp_valid) begin
                    state_d = ST_IDLE;
                    if (!wr_q)        rdata_d  = dmi_resp_rdata;
                    if (dmi_resp_err) sticky_d = 2'd2;
                end
            end
            default: ;
        endcase

        // Strobe effects are applied after the FSM so they win over a same-cycle response
        if (ch_dtmcs || ch_dmi) begin
            if (dmi_ch_capture_core) begin
                if (ch_dtmcs) begin
                    sr_d = SR_W'(dtmcs_cap);
                end else if (state_q != ST_IDLE) begin
                    sr_d     = {addr_q, rdata_q, 2'd3};
                    sticky_d = 2'd3;
                end else begin
                    sr_d = {addr_q, rdata_q, sticky_q};
                end
            end else if (dmi_ch_shift_core) begin
                if (ch_dtmcs) sr_d[31:0] = {dmi_ch_tdi_core, sr_q[31:1]};
                else          sr_d       = {dmi_ch_tdi_core, sr_q[SR_W-1:1]};
            end else if (dmi_ch_update_core) begin
                if (ch_dtmcs) begin
                    if (sr_q[17]) begin
                        sticky_d = 2'd0;
                        state_d  = ST_IDLE;
                        rdata_d  = rdata_q;
                    end else if (sr_q[16]) begin
                        sticky_d = 2'd0;
                    end
                end else if (sticky_q != 2'd0) begin
                    sticky_d = sticky_q;
                end else if (state_q != ST_IDLE) begin
                    sticky_d = 2'd3;
                end else if ((upd_op == 2'd1) || (upd_op == 2'd2)) begin
                    addr_d  = sr_q[SR_W-1:DBITS+2];
                    wdata_d = sr_q[DBITS+1:2];
                    wr_d    = (upd_op == 2'd2);
                    state_d = ST_REQ;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            sticky_q <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            sticky_q <= sticky_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
        end
    end

    assign dmi_ch_tdo_core = (ch_dtmcs || ch_dmi) ? sr_q[0] : 1'b0;
    assign dmi_req         = (state_q == ST_REQ);
    assign dmi_req_wr      = wr_q;
    assign dmi_req_addr    = addr_q;
    assign dmi_req_wdata   = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_scr1_dmi_chain_core.sv
// ============================================================================
// tb_scr1_dmi_chain_core : scoreboard bench for the DMI chain responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_scr1_dmi_chain_core;

    localparam int ABITS = 7;
    localparam int DBITS = 32;
    localparam int SR_W  = ABITS + DBITS + 2;

    logic             clk = 1'b0;
    logic             trst_n;
    logic             sel, capture, shift, update, tdi;
    logic [1:0]       ch_id;
    logic             tdo;
    logic             req, req_ack, req_wr;
    logic [ABITS-1:0] req_addr;
    logic [DBITS-1:0] req_wdata;
    logic             resp_valid, resp_err;
    logic [DBITS-1:0] resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [SR_W-1:0] dout;

    scr1_dmi_chain_core #(
        .ABITS(ABITS), .DBITS(DBITS), .CH_ID_W(2), .CH_ID_DTMCS(0), .CH_ID_DMI(1)
    ) dut (
        .clk                 (clk),
        .trst_n              (trst_n),
        .dmi_ch_sel_core     (sel),
        .dmi_ch_id_core      (ch_id),
        .dmi_ch_capture_core (capture),
        .dmi_ch_shift_core   (shift),
        .dmi_ch_update_core  (update),
        .dmi_ch_tdi_core     (tdi),
        .dmi_ch_tdo_core     (tdo),
        .dmi_req             (req),
        .dmi_req_ack         (req_ack),
        .dmi_req_wr          (req_wr),
        .dmi_req_addr        (req_addr),
        .dmi_req_wdata       (req_wdata),
        .dmi_resp_valid      (resp_valid),
        .dmi_resp_err        (resp_err),
        .dmi_resp_rdata      (resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SR_W-1:0] dmi_word(input logic [ABITS-1:0] a,
                                                 input logic [DBITS-1:0] d,
                                                 input logic [1:0] op);
        return {a, d, op};
    endfunction

    // Capture, shift n bits (tdo sampled LSB first), optionally update.
    task automatic scan(input logic [1:0] id, input int n, input logic [SR_W-1:0] din,
                        input bit upd, output logic [SR_W-1:0] res);
        res   = '0;
        sel   = 1'b1;
        ch_id = id;
        tick();
        capture = 1'b1; tick(); capture = 1'b0; tick();
        for (int i = 0; i < n; i++) begin
            res[i] = tdo;
            shift = 1'b1; tdi = din[i]; tick();
            shift = 1'b0; tdi = 1'b0; tick();
        end
        if (upd) begin
            update = 1'b1; tick(); update = 1'b0;
        end
    endtask

    task automatic sb_scan(input string tag, input logic [1:0] id, input int n,
                           input logic [SR_W-1:0] din, input bit upd,
                           input logic [SR_W-1:0] exp_cap);
        exp_q.push_back(64'(exp_cap));
        scan(id, n, din, upd, dout);
        check(tag, 64'(dout), exp_q.pop_front());
    endtask

    task automatic check_req(input string tag, input logic wr,
                             input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
        exp_q.push_back({23'd0, 1'b1, wr, a, d});
        check(tag, {23'd0, req, req_wr, req_addr, req_wdata}, exp_q.pop_front());
    endtask

    task automatic respond(input logic err, input logic [DBITS-1:0] rd);
        resp_valid = 1'b1; resp_err = err; resp_rdata = rd;
        tick();
        resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        trst_n = 1'b0; sel = 1'b0; ch_id = 2'd0; capture = 1'b0; shift = 1'b0;
        update = 1'b0; tdi = 1'b0; req_ack = 1'b0; resp_valid = 1'b0;
        resp_err = 1'b0; resp_rdata = '0;
        tick(); tick();
        check("rst_outs", {req, req_wr, tdo, 7'(req_addr), req_wdata}, 64'd0);
        trst_n = 1'b1;
        tick();

        sb_scan("rst_dmi_cap", 2'd1, SR_W, '0, 1'b0, '0);
        sb_scan("dtmcs_read", 2'd0, 32, '0, 1'b0, 41'h1071);

        // read of 0x11
        sb_scan("rd_cap", 2'd1, SR_W, dmi_word(7'h11, 32'h0, 2'd1), 1'b1, '0);
        check_req("rd_req", 1'b0, 7'h11, 32'h0);
        tick(); tick(); tick();
        check("rd_req_hold", 64'(req), 64'd1);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        check("rd_req_fall", 64'(req), 64'd0);
        respond(1'b0, 32'hDEADBEEF);
        sb_scan("rd_data", 2'd1, SR_W, '0, 1'b0, dmi_word(7'h11, 32'hDEADBEEF, 2'd0));

        // write with error response, ack in first REQ cycle
        sb_scan("wr_cap", 2'd1, SR_W, dmi_word(7'h04, 32'h80000001, 2'd2), 1'b1,
                dmi_word(7'h11, 32'hDEADBEEF, 2'd0));
        check_req("wr_req", 1'b1, 7'h04, 32'h80000001);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        respond(1'b1, 32'h12345678);
        sb_scan("wr_err", 2'd1, SR_W, dmi_word(7'h05, 32'h0, 2'd1), 1'b1,
                dmi_word(7'h04, 32'hDEADBEEF, 2'd2));
        tick();
        check("sticky_noreq", 64'(req), 64'd0);
        sb_scan("dtmcs_failed", 2'd0, 32, 41'h0001_0000, 1'b1, 41'h1871);
        sb_scan("dmireset_ok", 2'd1, SR_W, '0, 1'b0, dmi_word(7'h04, 32'hDEADBEEF, 2'd0));

        // busy then hardreset
        sb_scan("busy_cap0", 2'd1, SR_W, dmi_word(7'h22, 32'h0, 2'd1), 1'b1,
                dmi_word(7'h04, 32'hDEADBEEF, 2'd0));
        check_req("busy_req", 1'b0, 7'h22, 32'h0);
        sb_scan("busy_op3", 2'd1, SR_W, dmi_word(7'h33, 32'h0, 2'd1), 1'b1,
                dmi_word(7'h22, 32'hDEADBEEF, 2'd3));
        check_req("busy_noreissue", 1'b0, 7'h22, 32'h0);
        sb_scan("dtmcs_busy", 2'd0, 32, 41'h0002_0000, 1'b1, 41'h1C71);
        check("hardreset_drop", 64'(req), 64'd0);
        tick();
        respond(1'b1, 32'hBAD0BAD0);
        sb_scan("late_resp", 2'd1, SR_W, 41'h1, 1'b0, dmi_word(7'h22, 32'hDEADBEEF, 2'd0));

        // deselect: strobes ignored and tdo forced low
        sel = 1'b0; ch_id = 2'd1;
        capture = 1'b1; tick(); capture = 1'b0; tick();
        check("desel_tdo", 64'(tdo), 64'd0);
        shift = 1'b1; tdi = 1'b0; tick(); shift = 1'b0; tick();
        sel = 1'b1; ch_id = 2'd2;
        shift = 1'b1; tick(); shift = 1'b0; tick();
        check("badid_tdo", 64'(tdo), 64'd0);
        ch_id = 2'd1; #1;
        check("desel_sr_kept", 64'(tdo), 64'd1);

        // capture and update together: capture only
        sb_scan("prio_pre", 2'd1, SR_W, dmi_word(7'h44, 32'h0, 2'd1), 1'b0,
                dmi_word(7'h22, 32'hDEADBEEF, 2'd0));
        capture = 1'b1; update = 1'b1; tick(); capture = 1'b0; update = 1'b0;
        check("prio_noreq", 64'(req), 64'd0);
        check("prio_cap_tdo", 64'(tdo), 64'd0);
        tick();

        // asynchronous reset while in RESP
        sb_scan("arst_cap", 2'd1, SR_W, dmi_word(7'h55, 32'h0, 2'd1), 1'b1,
                dmi_word(7'h22, 32'hDEADBEEF, 2'd0));
        check_req("arst_req", 1'b0, 7'h55, 32'h0);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        #2 trst_n = 1'b0;
        #1;
        check("arst_outs", {req, req_wr, tdo, 7'(req_addr), req_wdata}, 64'd0);
        tick();
        trst_n = 1'b1;
        tick();
        respond(1'b1, 32'hCAFEF00D);
        sb_scan("arst_dmi", 2'd1, SR_W, '0, 1'b0, '0);
        sb_scan("arst_dtmcs", 2'd0, 32, '0, 1'b0, 41'h1071);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
